framebuffer_reader: RTL and testbench

FRAMEBUFFER_READER -- requirements
Module: framebuffer_reader

---
 rtl/framebuffer_reader.sv | 129 ++++++++++++
 tb/tb_framebuffer_reader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_reader.sv
// Framebuffer reader: fetches pixel words from memory into a small
// first-word-fall-through FIFO that feeds the display pipeline.
module framebuffer_reader #(
   parameter logic [18:0] FB_BASE = 19'd0,
   parameter int          NPIX    = 307200,
   parameter int          DEPTH   = 16
) (
   input  logic        i_pixclk,
   input  logic        i_reset_n,
   input  logic        i_rd,
   input  logic        i_newframe,
   output logic [7:0]  o_red,
   output logic [7:0]  o_grn,
   output logic [7:0]  o_blu,
   output logic        o_mem_req,
   output logic [18:0] o_mem_addr,
   input  logic        i_mem_ack,
   input  logic [23:0] i_mem_data,
   output logic        o_underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [18:0] ADDR_LAST = FB_BASE + 19'(NPIX - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DISCARD
   } state_t;

   state_t         state;
   logic           mem_req;
   logic           underflow;
   logic [18:0]    addr;
   logic [18:0]    addr_inc;
   logic [23:0]    fifo [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic [AW:0]    count_nx;
   logic           empty;
   logic           push;
   logic           pop;
   logic [23:0]    head;

   always_comb begin
      empty    = (count == '0);
      pop      = i_rd && !empty && !i_newframe;
      push     = (state == REQ) && i_mem_ack && !i_newframe;
      addr_inc = (addr == ADDR_LAST) ? FB_BASE : addr + 19'd1;
      count_nx = count;
      if (i_newframe)
         count_nx = '0;
      else
         count_nx = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   end

   // Storage needs no reset: entries are only visible while count > 0.
   always_ff @(posedge i_pixclk) begin
      if (push)
         fifo[wr_ptr] <= i_mem_data;
   end

   always_ff @(posedge i_pixclk) begin
      if (!i_reset_n) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         addr      <= FB_BASE;
         underflow <= 1'b0;
      end else begin
         count <= count_nx;
         if (i_newframe) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            addr      <= FB_BASE;
            underflow <= 1'b0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + 1'b1;
               addr   <= addr_inc;
            end
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
            if (i_rd && empty)
               underflow <= 1'b1;
         end
         // One request in flight at most, so room is judged on count alone.
         unique case (state)
            IDLE: begin
               if (count_nx < FULL) begin
                  state   <= REQ;
                  mem_req <= 1'b1;
               end
            end
            REQ: begin
               if (i_mem_ack) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
               end else if (i_newframe) begin
                  state   <= DISCARD;
                  mem_req <= 1'b0;
               end
            end
            DISCARD: begin
               // The accepted request still owes one ack; swallow it.
               if (i_mem_ack)
                  state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign head        = empty ? 24'd0 : fifo[rd_ptr];
   assign o_red       = head[23:16];
   assign o_grn       = head[15:8];
   assign o_blu       = head[7:0];
   assign o_mem_req   = mem_req;
   assign o_mem_addr  = addr;
   assign o_underflow = underflow;

endmodule

// File: tb/tb_framebuffer_reader.sv
// Bench for framebuffer_reader: queue-based pixel model plus a
// variable-latency memory that answers every accepted request once.
module tb_framebuffer_reader;

   localparam int DEPTH = 16;
   localparam int NPIX  = 40;

   logic        i_pixclk   = 1'b0;
   logic        i_reset_n  = 1'b0;
   logic        i_rd       = 1'b0;
   logic        i_newframe = 1'b0;
   logic        i_mem_ack  = 1'b0;
   logic [23:0] i_mem_data = 24'd0;
   logic [7:0]  o_red;
   logic [7:0]  o_grn;
   logic [7:0]  o_blu;
   logic        o_mem_req;
   logic [18:0] o_mem_addr;
   logic        o_underflow;

   always #5 i_pixclk = ~i_pixclk;

   framebuffer_reader #(
      .FB_BASE (19'd0),
      .NPIX    (NPIX),
      .DEPTH   (DEPTH)
   ) dut (
      .i_pixclk    (i_pixclk),
      .i_reset_n   (i_reset_n),
      .i_rd        (i_rd),
      .i_newframe  (i_newframe),
      .o_red       (o_red),
      .o_grn       (o_grn),
      .o_blu       (o_blu),
      .o_mem_req   (o_mem_req),
      .o_mem_addr  (o_mem_addr),
      .i_mem_ack   (i_mem_ack),
      .i_mem_data  (i_mem_data),
      .o_underflow (o_underflow)
   );

   int total = 0;
   int bad   = 0;

   // reference: pixels held, next fetch address, request bookkeeping
   logic [23:0] q[$];
   int          nxt   = 0;
   bit          outst = 0;
   bit          vis   = 0;
   int          raddr = 0;
   bit          uf    = 0;

   // memory side
   bit          m_busy  = 0;
   int          m_lat   = 0;
   int          m_addr  = 0;
   int          lat_cfg = 1;
   logic [23:0] salt    = 24'd0;
   bit          cap_now = 0;
   int          nreq    = 0;
   int          last_cap = -1;
   int          wraps   = 0;

   function automatic logic [23:0] word(input int a);
      return 24'(a) ^ salt;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit rstn, input bit rd, input bit nf,
                             input bit ack, input logic [23:0] data);
      bit push;
      if (!rstn) begin
         q.delete();
         nxt   = 0;
         uf    = 0;
         outst = 0;
         vis   = 0;
      end else begin
         push = outst && vis && ack && !nf;
         if (nf) begin
            q.delete();
            nxt = 0;
            uf  = 0;
         end else begin
            if (rd) begin
               if (q.size() == 0) uf = 1;
               else void'(q.pop_front());
            end
            if (push) begin
               q.push_back(data);
               nxt = (nxt + 1) % NPIX;
            end
         end
         if (outst) begin
            if (ack) begin
               outst = 0;
               vis   = 0;
            end else if (nf) begin
               vis = 0;
            end
         end else if (q.size() < DEPTH) begin
            outst = 1;
            vis   = 1;
            raddr = nxt;
         end
      end
   endtask

   task automatic cyc(input bit rstn, input bit rd, input bit nf);
      logic [23:0] exp_pix;
      i_reset_n  = rstn;
      i_rd       = rd;
      i_newframe = nf;
      i_mem_ack  = m_busy && (m_lat == 0);
      i_mem_data = i_mem_ack ? word(m_addr) : 24'($urandom);
      @(posedge i_pixclk);
      model_edge(rstn, rd, nf, i_mem_ack, i_mem_data);
      if (i_mem_ack) m_busy = 0;
      else if (m_busy) m_lat--;
      @(negedge i_pixclk);
      chk("mem_req", {31'd0, o_mem_req}, {31'd0, vis});
      if (vis) chk("mem_addr", {13'd0, o_mem_addr}, raddr);
      if (o_mem_req && m_busy)
         chk("addr_hold", {13'd0, o_mem_addr}, m_addr);
      exp_pix = (q.size() > 0) ? q[0] : 24'd0;
      chk("pixel", {8'd0, o_red, o_grn, o_blu}, {8'd0, exp_pix});
      chk("underflow", {31'd0, o_underflow}, {31'd0, uf});
      cap_now = 0;
      if (!m_busy && o_mem_req) begin
         m_busy  = 1;
         m_addr  = int'(o_mem_addr);
         m_lat   = lat_cfg;
         cap_now = 1;
         nreq++;
         if (m_addr == 0 && last_cap == NPIX - 1) wraps++;
         last_cap = m_addr;
      end
   endtask

   initial begin
      bit found;

      // reset state
      repeat (3) cyc(0, 0, 0);
      chk("rst_req", {31'd0, o_mem_req}, 0);
      chk("rst_pix", {8'd0, o_red, o_grn, o_blu}, 0);
      chk("rst_uf", {31'd0, o_underflow}, 0);

      // fill with 1-cycle memory, no consumption
      nreq    = 0;
      lat_cfg = 1;
      cyc(1, 0, 0);
      chk("first_req", {31'd0, o_mem_req}, 1);
      chk("first_addr", {13'd0, o_mem_addr}, 0);
      repeat (80) cyc(1, 0, 0);
      chk("fill_nreq", nreq, DEPTH);
      chk("fill_idle", {31'd0, o_mem_req}, 0);
      chk("fill_head", {8'd0, o_red, o_grn, o_blu}, 0);

      // drain while memory keeps up, then stall memory
      repeat (16) cyc(1, 1, 0);
      chk("drain_uf", {31'd0, o_underflow}, 0);
      lat_cfg = 40;
      repeat (30) cyc(1, 1, 0);
      chk("stall_uf", {31'd0, o_underflow}, 1);
      chk("stall_pix", {8'd0, o_red, o_grn, o_blu}, 0);
      repeat (20) cyc(1, 0, 0);

      // address wrap with instant memory
      lat_cfg = 0;
      wraps   = 0;
      for (int i = 0; i < 160; i++) cyc(1, i[0], 0);
      chk("wrap_seen", {31'd0, wraps > 0}, 1);

      // newframe mid-request, ack three cycles later
      lat_cfg = 3;
      found   = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         cyc(1, 1, 0);
         found = cap_now;
      end
      chk("wait_req36", {31'd0, found}, 1);
      cyc(1, 0, 1);
      chk("nf36_req", {31'd0, o_mem_req}, 0);
      chk("nf36_pix", {8'd0, o_red, o_grn, o_blu}, 0);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         cyc(1, 0, 0);
         found = o_mem_req;
      end
      chk("nf36_wait", {31'd0, found}, 1);
      chk("nf36_addr", {13'd0, o_mem_addr}, 0);
      repeat (10) cyc(1, 0, 0);

      // newframe coincident with ack, pop and underflow
      lat_cfg = 6;
      found   = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         cyc(1, 1, 0);
         found = m_busy && (m_lat == 0) && o_mem_req;
      end
      chk("wait_req37", {31'd0, found}, 1);
      cyc(1, 1, 1);
      chk("nf37_uf", {31'd0, o_underflow}, 0);
      chk("nf37_pix", {8'd0, o_red, o_grn, o_blu}, 0);
      cyc(1, 0, 0);
      chk("nf37_req", {31'd0, o_mem_req}, 1);
      chk("nf37_addr", {13'd0, o_mem_addr}, 0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         lat_cfg = $urandom_range(0, 3);
         if (i % 300 == 0) salt = 24'($urandom);
         cyc(1, ($urandom_range(0, 99) < 45), ($urandom_range(0, 59) == 0));
      end

      // one-cycle reset mid-request, then a late ack
      lat_cfg = 20;
      found   = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         cyc(1, 0, 0);
         found = cap_now;
      end
      chk("wait_req38", {31'd0, found}, 1);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      m_lat   = 0;
      lat_cfg = 2;
      cyc(1, 0, 0);
      chk("rst38_req", {31'd0, o_mem_req}, 1);
      chk("rst38_addr", {13'd0, o_mem_addr}, 0);
      chk("rst38_pix", {8'd0, o_red, o_grn, o_blu}, 0);
      repeat (40) cyc(1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
